// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared constants and width helpers for the multi-button debouncer.
//   The default timing targets the 100 MHz board clock:
//     STABLE_CYCLES 65536  ~0.66 ms of agreeing samples before a level is taken
//     REPEAT_DELAY  2**24  ~168 ms hold before the first auto-repeat
//     REPEAT_PERIOD 2**22  ~42 ms between subsequent auto-repeats
//   No ports (package).
// -----------------------------------------------------------------------------
package debounce_pkg;

  localparam int DEF_NUM_BTN       = 5;
  localparam int DEF_STABLE_CYCLES = 65536;
  localparam int DEF_REPEAT_EN     = 1;
  localparam int DEF_REPEAT_DELAY  = 2 ** 24;
  localparam int DEF_REPEAT_PERIOD = 2 ** 22;

  // Debounce counter width (CNT_W): it only has to reach STABLE_CYCLES-1.
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
  endfunction

  // Hold counter width (HOLD_W): must be able to hold REPEAT_DELAY itself.
  function automatic int hold_width(input int repeat_delay);
    return (repeat_delay < 1) ? 1 : $clog2(repeat_delay + 1);
  endfunction

endpackage

// File: rtl/multi_btn_debouncer_if.sv
// -----------------------------------------------------------------------------
// multi_btn_debouncer_if
//   Bundles the raw button inputs and the conditioned outputs of the debouncer.
//   Signals (all NUM_BTN wide, one bit per button):
//     btn_raw      raw, asynchronous, bouncing inputs, 1 = pressed
//     btn_level    debounced level
//     btn_press    one-cycle pulse on an accepted 0->1
//     btn_release  one-cycle pulse on an accepted 1->0
//     btn_repeat   one-cycle auto-repeat pulse while held
//   Modports:
//     master  button/consumer side: drives btn_raw, reads the conditioned outputs
//     slave   debouncer side: reads btn_raw, drives the conditioned outputs
// -----------------------------------------------------------------------------
interface multi_btn_debouncer_if
  import debounce_pkg::*;
#(
  parameter int NUM_BTN = DEF_NUM_BTN
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_repeat;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );

endinterface

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One button channel: 2-flop synchroniser, symmetric debounce counter,
//   registered press/release pulses and an auto-repeat hold counter.
//   Ports:
//     the_clk      in   system clock, rising edge
//     rst          in   synchronous, active-high reset
//     btn_raw      in   raw bouncing button, 1 = pressed
//     btn_level    out  debounced level
//     btn_press    out  one-cycle pulse in the first cycle of level 1
//     btn_release  out  one-cycle pulse in the first cycle of level 0
//     btn_repeat   out  one-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic the_clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int CNT_W  = cnt_width(STABLE_CYCLES);
  localparam int HOLD_W = hold_width(REPEAT_DELAY);

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
  // Reloading to DELAY-PERIOD makes the same compare value fire every PERIOD.
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic              sync1, sync2;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [HOLD_W-1:0] hcnt, hcnt_nxt;
  logic              accept;
  logic              level_nxt;
  logic              repeat_nxt;

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    accept     = 1'b0;
    cnt_nxt    = '0;
    level_nxt  = btn_level;
    hcnt_nxt   = '0;
    repeat_nxt = 1'b0;

    // Debounce: count consecutive disagreeing samples; any agreeing sample
    // drops the count back to zero, so a glitch restarts the window.
    if (sync2 != btn_level) begin
      if (cnt == CNT_LAST) begin
        accept    = 1'b1;
        level_nxt = sync2;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end

    // Hold counter only runs while the level is 1 before and after this edge:
    // the press edge leaves it cleared and the release edge cancels any
    // pending repeat.
    if (btn_level && level_nxt) begin
      if (hcnt == HOLD_LAST) begin
        repeat_nxt = 1'b1;
        hcnt_nxt   = HOLD_RELOAD;
      end else begin
        hcnt_nxt = hcnt + HOLD_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge the_clk) begin
    if (rst) begin
      // NOTE: the synchroniser is reset as well, so a button held through
      // reset is seen as a fresh 0->1 and produces a new press.
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      cnt         <= '0;
      hcnt        <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      cnt         <= cnt_nxt;
      hcnt        <= hcnt_nxt;
      btn_level   <= level_nxt;
      btn_press   <= accept &  sync2;
      btn_release <= accept & ~sync2;
      btn_repeat  <= repeat_nxt;
    end
  end

endmodule

// File: rtl/multi_btn_debouncer.sv
// -----------------------------------------------------------------------------
// multi_btn_debouncer
//   N-channel push-button conditioner. Each button gets its own independent
//   debounce_channel; the auto-repeat output can be compiled out.
//   Ports:
//     the_clk   in     system clock, all logic on the rising edge
//     rst       in     synchronous, active-high reset
//     btn       slave  multi_btn_debouncer_if: btn_raw in; btn_level,
//                      btn_press, btn_release, btn_repeat out
// -----------------------------------------------------------------------------
module multi_btn_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_BTN       = DEF_NUM_BTN,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_EN     = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input logic                  the_clk,
  input logic                  rst,
  multi_btn_debouncer_if.slave btn
);

  logic [NUM_BTN-1:0] ch_level;
  logic [NUM_BTN-1:0] ch_press;
  logic [NUM_BTN-1:0] ch_release;
  logic [NUM_BTN-1:0] ch_repeat;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .the_clk     (the_clk),
      .rst         (rst),
      .btn_raw     (btn.btn_raw[i]),
      .btn_level   (ch_level[i]),
      .btn_press   (ch_press[i]),
      .btn_release (ch_release[i]),
      .btn_repeat  (ch_repeat[i])
    );
  end

  assign btn.btn_level   = ch_level;
  assign btn.btn_press   = ch_press;
  assign btn.btn_release = ch_release;
  // With repeat disabled the hold counters have no load and get pruned.
  assign btn.btn_repeat  = (REPEAT_EN != 0) ? ch_repeat : '0;

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_btn_debouncer
//   Drives two debouncers (auto-repeat on and off) from the same buttons.
//   A window-based reference model predicts every cycle's outputs into a
//   queue; an independent monitor pops and compares. Directed scenarios add
//   timing checks against fixed edge numbers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multi_btn_debouncer;

  localparam int NB = 4;
  localparam int S  = 8;
  localparam int D  = 32;
  localparam int PD = 16;

  logic          the_clk = 1'b0;
  logic          rst;
  logic [NB-1:0] raw;

  always #5 the_clk = ~the_clk;

  multi_btn_debouncer_if #(.NUM_BTN(NB)) bus1 ();
  multi_btn_debouncer_if #(.NUM_BTN(NB)) bus0 ();

  assign bus1.btn_raw = raw;
  assign bus0.btn_raw = raw;

  multi_btn_debouncer #(
    .NUM_BTN(NB), .STABLE_CYCLES(S), .REPEAT_EN(1),
    .REPEAT_DELAY(D), .REPEAT_PERIOD(PD)
  ) dut1 (.the_clk(the_clk), .rst(rst), .btn(bus1));

  multi_btn_debouncer #(
    .NUM_BTN(NB), .STABLE_CYCLES(S), .REPEAT_EN(0),
    .REPEAT_DELAY(D), .REPEAT_PERIOD(PD)
  ) dut0 (.the_clk(the_clk), .rst(rst), .btn(bus0));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    int          n;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic [NB-1:0] rep;
  } exp_t;

  exp_t          exp_q[$];
  logic [NB-1:0] hist[$];      // hist[k-1] = raw sampled at edge k
  logic [NB-1:0] m_lvl;
  int            m_last_flip[NB];
  int            m_press_at[NB];
  int            n = 0;        // edges since reset released

  function automatic logic raw_at(input int k, input int ch);
    logic [NB-1:0] v;
    if (k < 1) return 1'b0;
    v = hist[k-1];
    return v[ch];
  endfunction

  // A level flips at edge m when the S samples that reached the comparator
  // at edges m-S+1..m (raw at edges m-S-1..m-2) all disagree with it and all
  // arrived after the previous flip. Repeats fall at press+D+j*PD.
  initial begin : model
    exp_t e;
    logic stable;
    int   d;
    forever begin
      @(posedge the_clk);
      e = '0;
      if (rst) begin
        hist.delete();
        m_lvl = '0;
        n     = 0;
        for (int c = 0; c < NB; c++) begin
          m_last_flip[c] = 0;
          m_press_at[c]  = 0;
        end
      end else begin
        n++;
        hist.push_back(raw);
        for (int c = 0; c < NB; c++) begin
          stable = (n >= m_last_flip[c] + S);
          for (int k = n - S - 1; k <= n - 2; k++)
            if (raw_at(k, c) == m_lvl[c]) stable = 1'b0;
          if (stable) begin
            m_lvl[c]       = ~m_lvl[c];
            m_last_flip[c] = n;
            if (m_lvl[c]) begin
              e.prs[c]      = 1'b1;
              m_press_at[c] = n;
            end else begin
              e.rel[c] = 1'b1;
            end
          end else if (m_lvl[c]) begin
            d = n - m_press_at[c];
            if (d >= D && ((d - D) % PD) == 0) e.rep[c] = 1'b1;
          end
        end
      end
      e.n   = n;
      e.lvl = m_lvl;
      exp_q.push_back(e);
    end
  end

  // -------------------------------------------------------------- monitor
  int obs_press_cnt[NB];
  int obs_press_edge[NB];
  int rep3_edges[$];
  int rel3_edge   = -1;
  int overlap_cnt = 0;
  int d0_rep_cnt  = 0;

  initial begin : monitor
    exp_t e;
    for (int c = 0; c < NB; c++) begin
      obs_press_cnt[c]  = 0;
      obs_press_edge[c] = -1;
    end
    forever begin
      @(negedge the_clk);
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("dut1_outputs_n%0d", e.n),
              {bus1.btn_level, bus1.btn_press, bus1.btn_release, bus1.btn_repeat},
              {e.lvl, e.prs, e.rel, e.rep});
        check($sformatf("dut0_outputs_n%0d", e.n),
              {bus0.btn_level, bus0.btn_press, bus0.btn_release, bus0.btn_repeat},
              {e.lvl, e.prs, e.rel, {NB{1'b0}}});
        for (int c = 0; c < NB; c++) begin
          if (bus1.btn_press[c]) begin
            obs_press_cnt[c]++;
            obs_press_edge[c] = e.n;
          end
        end
        if (bus1.btn_repeat[3]) rep3_edges.push_back(e.n);
        if (bus1.btn_release[3]) rel3_edge = e.n;
        if (((bus1.btn_press | bus1.btn_release) & bus1.btn_repeat) != '0) overlap_cnt++;
        if (bus0.btn_repeat != '0) d0_rep_cnt++;
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic wait_n(input int t);
    int guard = 0;
    while (n < t && guard < 1000) begin
      @(negedge the_clk);
      guard++;
    end
    if (n < t) check("wait_timeout", n, t);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int a, b, c, f, p;
    int run_left[NB];
    bit bounce[6] = '{1, 0, 1, 1, 0, 1};

    rst = 1'b1;
    raw = '0;
    repeat (3) @(negedge the_clk);
    check("reset_state",
          {bus1.btn_level, bus1.btn_press, bus1.btn_release, bus1.btn_repeat,
           bus0.btn_level, bus0.btn_press, bus0.btn_release, bus0.btn_repeat}, 0);
    rst = 1'b0;

    // 1: clean press sampled at edge 10 -> level/press at edge 19 only.
    wait_n(9);
    raw[0] = 1'b1;
    wait_n(18);
    check("s1_no_early_press", {bus1.btn_level, bus1.btn_press}, 0);
    wait_n(19);
    check("s1_press_edge19", {bus1.btn_level, bus1.btn_press}, {4'b0001, 4'b0001});
    wait_n(20);
    check("s1_single_pulse", bus1.btn_press, 0);

    // 2: bounce 1,0,1,1,0 then steady 1 on channel 1.
    wait_n(22);
    a = n;
    for (int i = 0; i < 6; i++) begin
      raw[1] = bounce[i];
      if (i < 5) @(negedge the_clk);
    end
    wait_n(a + 30);
    check("s2_press_count", obs_press_cnt[1], 1);
    check("s2_press_edge", obs_press_edge[1], a + 15);

    // 3: seven-cycle glitch on channel 2 is rejected.
    b = n;
    raw[2] = 1'b1;
    repeat (7) @(negedge the_clk);
    raw[2] = 1'b0;
    wait_n(b + 30);
    check("s3_glitch_level", bus1.btn_level[2], 0);
    check("s3_glitch_press", obs_press_cnt[2], 0);

    // 4: auto-repeat on channel 3, held 80 cycles past press.
    c = n;
    raw[3] = 1'b1;
    p = c + 10;
    wait_n(p);
    check("s4_press_edge", obs_press_edge[3], p);
    wait_n(p + 80);
    raw[3] = 1'b0;
    wait_n(p + 100);
    check("s4_repeat_count", rep3_edges.size(), 4);
    check("s4_first_repeat",  (rep3_edges.size() > 0) ? rep3_edges[0] - p : -1, 32);
    check("s4_second_repeat", (rep3_edges.size() > 1) ? rep3_edges[1] - p : -1, 48);
    check("s4_release_delay", rel3_edge - (p + 80), 10);

    // 5: one-cycle reset while channel 0 is held and mid-count.
    raw[0] = 1'b0;
    repeat (20) @(negedge the_clk);
    raw[0] = 1'b1;
    repeat (4) @(negedge the_clk);
    rst = 1'b1;
    @(negedge the_clk);
    check("s5_reset_outputs",
          {bus1.btn_level, bus1.btn_press, bus1.btn_release, bus1.btn_repeat,
           bus0.btn_level, bus0.btn_press, bus0.btn_release, bus0.btn_repeat}, 0);
    rst = 1'b0;
    wait_n(9);
    check("s5_no_early_press", bus1.btn_press[0], 0);
    wait_n(10);
    check("s5_press_after_reset", bus1.btn_press[0], 1);

    // 6: channels 0 and 2 pressed together.
    raw = '0;
    repeat (30) @(negedge the_clk);
    f = n;
    raw = 4'b0101;
    wait_n(f + 10);
    check("s6_concurrent_dut1", bus1.btn_press, 4'b0101);
    check("s6_concurrent_dut0", bus0.btn_press, 4'b0101);

    // Randomised bouncing, long holds and occasional resets.
    for (int i = 0; i < NB; i++) run_left[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge the_clk);
      rst = ($urandom_range(0, 999) == 0);
      for (int i = 0; i < NB; i++) begin
        if (run_left[i] == 0) begin
          raw[i]      = 1'($urandom_range(0, 1));
          run_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                    : int'($urandom_range(5, 100));
        end else begin
          run_left[i]--;
        end
      end
    end
    @(negedge the_clk);
    rst = 1'b0;
    raw = '0;
    repeat (40) @(negedge the_clk);

    check("tieoff_repeat_zero", d0_rep_cnt, 0);
    check("no_repeat_with_edge", overlap_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
